// File: rtl/sat_shift_agc.sv
`default_nettype none
// ============================================================================
//  Module      : sat_shift_agc
//  Description : Receive-path gain stage. Arithmetic right shift of a wide
//                signed sample, symmetric saturation to OSZ bits, and a
//                windowed saturation counter that steps the shift
//                automatically (auto_en=1) or follows a software value
//                (auto_en=0).
//  Ports       : clk, rst            - clock, async active-high reset
//                in, in_valid        - signed input sample and qualifier
//                auto_en             - 1 = automatic shift, 0 = manual
//                shift_manual        - shift used in manual mode
//                out, out_valid, sat - registered result, qualifier, clamp flag
//                shift               - shift currently applied
//                sat_count_last      - saturation count of last full window
//                shift_changed       - one-cycle pulse on automatic change
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_shift_agc #(
    parameter int ISZ       = 17,
    parameter int OSZ       = 12,
    parameter int SHW       = 3,
    parameter int MAX_SHIFT = 5,
    parameter int WIN_LOG2  = 10,
    parameter int SAT_THR   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ISZ-1:0]      in,
    input  logic                in_valid,
    input  logic                auto_en,
    input  logic [SHW-1:0]      shift_manual,
    output logic [OSZ-1:0]      out,
    output logic                out_valid,
    output logic                sat,
    output logic [SHW-1:0]      shift,
    output logic [WIN_LOG2:0]   sat_count_last,
    output logic                shift_changed
);

    // Clamp limits expressed at input width so the comparison is exact.
    localparam logic signed [ISZ-1:0] c_pos_lim   = ISZ'((1 <<< (OSZ-1)) - 1);
    localparam logic signed [ISZ-1:0] c_neg_lim   = ~c_pos_lim;
    localparam logic [OSZ-1:0]        c_pos_out   = {1'b0, {(OSZ-1){1'b1}}};
    localparam logic [OSZ-1:0]        c_neg_out   = {1'b1, {(OSZ-1){1'b0}}};
    localparam logic [SHW-1:0]        c_max_shift = SHW'(MAX_SHIFT);
    localparam logic [SHW-1:0]        c_shift_one = SHW'(1);
    localparam logic [WIN_LOG2:0]     c_sat_thr   = (WIN_LOG2+1)'(SAT_THR);
    localparam logic [WIN_LOG2-1:0]   c_win_last  = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0]   c_win_one   = WIN_LOG2'(1);

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_DECIDE = 1'b1
    } state_t;

    state_t                 r_state;
    logic [OSZ-1:0]         r_out;
    logic                   r_out_valid;
    logic                   r_sat;
    logic [SHW-1:0]         r_shift;
    logic [WIN_LOG2:0]      r_sat_count_last;
    logic                   r_shift_changed;
    logic [WIN_LOG2-1:0]    r_win_cnt;
    logic [WIN_LOG2:0]      r_sat_cnt;
    logic                   r_any_high;
    logic                   r_hold;

    logic signed [ISZ-1:0]  w_shifted;
    logic [OSZ-1:0]         w_sample;
    logic                   w_sat;
    logic                   w_high;
    logic [SHW-1:0]         w_shift_man;
    logic [WIN_LOG2:0]      w_sat_inc;

    assign w_shifted = $signed(in) >>> r_shift;

    always_comb begin
        w_sample = w_shifted[OSZ-1:0];
        w_sat    = 1'b0;
        if (w_shifted > c_pos_lim) begin
            w_sample = c_pos_out;
            w_sat    = 1'b1;
        end else if (w_shifted < c_neg_lim) begin
            w_sample = c_neg_out;
            w_sat    = 1'b1;
        end
    end

    // Top three bits not all equal means |sample| >= 2^(OSZ-3).
    assign w_high = !((w_sample[OSZ-1] == w_sample[OSZ-2]) &&
                      (w_sample[OSZ-2] == w_sample[OSZ-3]));

    assign w_shift_man = (shift_manual > c_max_shift) ? c_max_shift : shift_manual;
    assign w_sat_inc   = {{WIN_LOG2{1'b0}}, w_sat};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_ACCUM;
            r_out            <= '0;
            r_out_valid      <= 1'b0;
            r_sat            <= 1'b0;
            r_shift          <= '0;
            r_sat_count_last <= '0;
            r_shift_changed  <= 1'b0;
            r_win_cnt        <= '0;
            r_sat_cnt        <= '0;
            r_any_high       <= 1'b0;
            r_hold           <= 1'b0;
        end else begin
            r_out_valid     <= in_valid;
            r_shift_changed <= 1'b0;
            if (in_valid) begin
                r_out <= w_sample;
                r_sat <= w_sat;
            end

            if (!auto_en) begin
                // Manual: follow software, keep the controller idle and clean
                // so re-enabling starts a fresh window from this shift.
                r_shift    <= w_shift_man;
                r_win_cnt  <= '0;
                r_sat_cnt  <= '0;
                r_any_high <= 1'b0;
                r_hold     <= 1'b0;
                r_state    <= ST_ACCUM;
            end else begin
                case (r_state)
                    ST_ACCUM: begin
                        if (in_valid) begin
                            r_win_cnt  <= r_win_cnt + c_win_one;
                            r_sat_cnt  <= r_sat_cnt + w_sat_inc;
                            r_any_high <= r_any_high | w_high;
                            if (r_win_cnt == c_win_last) begin
                                r_state <= ST_DECIDE;
                            end
                        end
                    end
                    ST_DECIDE: begin
                        r_sat_count_last <= r_sat_cnt;
                        if (r_hold) begin
                            // Skip one window after a change to let it settle.
                            r_hold <= 1'b0;
                        end else if ((r_sat_cnt > c_sat_thr) && (r_shift < c_max_shift)) begin
                            r_shift         <= r_shift + c_shift_one;
                            r_hold          <= 1'b1;
                            r_shift_changed <= 1'b1;
                        end else if (!r_any_high && (r_shift != '0)) begin
                            r_shift         <= r_shift - c_shift_one;
                            r_hold          <= 1'b1;
                            r_shift_changed <= 1'b1;
                        end
                        // A sample arriving now was shaped with the old shift
                        // and opens the next window.
                        r_win_cnt  <= in_valid ? c_win_one : '0;
                        r_sat_cnt  <= (in_valid && w_sat) ? {{WIN_LOG2{1'b0}}, 1'b1} : '0;
                        r_any_high <= in_valid & w_high;
                        r_state    <= ST_ACCUM;
                    end
                    default: r_state <= ST_ACCUM;
                endcase
            end
        end
    end

    assign out            = r_out;
    assign out_valid      = r_out_valid;
    assign sat            = r_sat;
    assign shift          = r_shift;
    assign sat_count_last = r_sat_count_last;
    assign shift_changed  = r_shift_changed;

endmodule
`default_nettype wire

// File: tb/tb_sat_shift_agc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sat_shift_agc
//  Description : Self-checking bench for sat_shift_agc with 16-sample windows.
//                Manual datapath vectors come from a table; automatic-mode
//                sequences are hand-written.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_shift_agc;

    localparam int ISZ       = 17;
    localparam int OSZ       = 12;
    localparam int SHW       = 3;
    localparam int MAX_SHIFT = 5;
    localparam int WIN_LOG2  = 4;
    localparam int SAT_THR   = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic signed [ISZ-1:0]  din;
    logic                   din_valid;
    logic                   auto_en;
    logic [SHW-1:0]         shift_manual;
    logic signed [OSZ-1:0]  dout;
    logic                   dout_valid;
    logic                   sat;
    logic [SHW-1:0]         shift;
    logic [WIN_LOG2:0]      scl;
    logic                   shift_changed;

    int checks   = 0;
    int failures = 0;

    sat_shift_agc #(
        .ISZ(ISZ), .OSZ(OSZ), .SHW(SHW), .MAX_SHIFT(MAX_SHIFT),
        .WIN_LOG2(WIN_LOG2), .SAT_THR(SAT_THR)
    ) dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(din_valid),
        .auto_en(auto_en), .shift_manual(shift_manual),
        .out(dout), .out_valid(dout_valid), .sat(sat), .shift(shift),
        .sat_count_last(scl), .shift_changed(shift_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sm;
        int din;
        int exp_out;
        int exp_sat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of input at the falling edge, return just after the
    // rising edge that consumed it.
    task automatic cyc(input int v, input logic val);
        @(negedge clk);
        din       = ISZ'(v);
        din_valid = val;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " out"}, int'(dout), 0);
        chk({tag, " out_valid"}, int'(dout_valid), 0);
        chk({tag, " sat"}, int'(sat), 0);
        chk({tag, " shift"}, int'(shift), 0);
        chk({tag, " sat_count_last"}, int'(scl), 0);
        chk({tag, " shift_changed"}, int'(shift_changed), 0);
    endtask

    task automatic chk_decide(input string tag, input int es, input int ep, input int ec);
        chk({tag, " shift"}, int'(shift), es);
        chk({tag, " shift_changed"}, int'(shift_changed), ep);
        chk({tag, " sat_count_last"}, int'(scl), ec);
    endtask

    // 16 back-to-back valid samples (ns of value vs, then vr), then an idle
    // cycle in which the decision is taken.
    task automatic window(input int vs, input int ns, input int vr,
                          input int es, input int ep, input int ec, input string tag);
        for (int i = 0; i < 16; i++) cyc((i < ns) ? vs : vr, 1'b1);
        cyc(0, 1'b0);
        chk_decide(tag, es, ep, ec);
        cyc(0, 1'b0);
        chk({tag, " pulse_clear"}, int'(shift_changed), 0);
    endtask

    // Same window with in_valid at 1-in-3.
    task automatic gapped(input int vs, input int ns,
                          input int es, input int ep, input int ec, input string tag);
        for (int i = 0; i < 16; i++) begin
            cyc((i < ns) ? vs : 0, 1'b1);
            chk({tag, " out_valid_on"}, int'(dout_valid), 1);
            cyc(0, 1'b0);
            chk({tag, " out_valid_gap1"}, int'(dout_valid), 0);
            if (i == 15) chk_decide(tag, es, ep, ec);
            else chk({tag, " early_pulse"}, int'(shift_changed), 0);
            cyc(0, 1'b0);
            chk({tag, " out_valid_gap2"}, int'(dout_valid), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{7,  65535,  2047, 0};  // exactly max after shift 5
        vecs[1]  = '{7, -65536, -2048, 0};  // exactly min after shift 5
        vecs[2]  = '{7,   1000,    31, 0};
        vecs[3]  = '{4,  65535,  2047, 1};
        vecs[4]  = '{4, -65536, -2048, 1};
        vecs[5]  = '{0,   2047,  2047, 0};
        vecs[6]  = '{0,   2048,  2047, 1};
        vecs[7]  = '{0,  -2049, -2048, 1};
        vecs[8]  = '{0,  -2048, -2048, 0};
        vecs[9]  = '{1,     -3,    -2, 0};
        vecs[10] = '{6,  -1000,   -32, 0};
        vecs[11] = '{3,   4000,   500, 0};

        rst = 1'b1; din = '0; din_valid = 1'b0; auto_en = 1'b0; shift_manual = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Manual-mode datapath table.
        for (int i = 0; i < 12; i++) begin
            shift_manual = SHW'(vecs[i].sm);
            cyc(0, 1'b0);
            cyc(vecs[i].din, 1'b1);
            chk($sformatf("vec%0d out", i), int'(dout), vecs[i].exp_out);
            chk($sformatf("vec%0d sat", i), int'(sat), vecs[i].exp_sat);
            chk($sformatf("vec%0d out_valid", i), int'(dout_valid), 1);
            chk($sformatf("vec%0d shift", i), int'(shift),
                (vecs[i].sm > MAX_SHIFT) ? MAX_SHIFT : vecs[i].sm);
        end
        cyc(0, 1'b0);
        chk("hold out", int'(dout), 500);
        chk("hold out_valid", int'(dout_valid), 0);

        // Automatic step-up, hold, second step, threshold edge.
        shift_manual = 3'd0;
        cyc(0, 1'b0);
        auto_en = 1'b1;
        window(8000, 5, 0, 1, 1, 5, "up1");
        window(8000, 5, 0, 1, 0, 5, "up_hold");
        window(8000, 5, 0, 2, 1, 5, "up2");
        window(16000, 4, 0, 2, 0, 4, "thr_hold");
        window(16000, 4, 0, 2, 0, 4, "thr_edge");

        // Step to MAX_SHIFT then stay there.
        auto_en = 1'b0; shift_manual = 3'd4;
        cyc(0, 1'b0);
        auto_en = 1'b1;
        window(65535, 16, 0, 5, 1, 16, "to_max");
        window(65535, 16, 0, 5, 0, 0, "max_hold");
        window(65535, 16, 0, 5, 0, 0, "max_cap");

        // Step-down blocked by a high sample, then allowed.
        auto_en = 1'b0; shift_manual = 3'd3;
        cyc(0, 1'b0);
        auto_en = 1'b1;
        window(4096, 1, 0, 3, 0, 0, "no_down");
        window(100, 16, 100, 2, 1, 0, "down");

        // Valid sample coincident with the decision cycle.
        auto_en = 1'b0; shift_manual = 3'd0;
        cyc(0, 1'b0);
        auto_en = 1'b1;
        for (int i = 0; i < 16; i++) cyc(3000, 1'b1);
        cyc(3000, 1'b1);
        chk("coinc out", int'(dout), 2047);
        chk("coinc sat", int'(sat), 1);
        chk_decide("coinc", 1, 1, 16);
        for (int i = 0; i < 15; i++) cyc(0, 1'b1);
        cyc(0, 1'b0);
        chk_decide("coinc_next", 1, 0, 1);
        cyc(0, 1'b0);

        // auto_en dropped mid-window discards the partial window.
        for (int i = 0; i < 8; i++) cyc(8000, 1'b1);
        auto_en = 1'b0; shift_manual = 3'd1;
        cyc(0, 1'b0);
        chk_decide("toggle_off", 1, 0, 1);
        auto_en = 1'b1;
        for (int i = 0; i < 8; i++) cyc(0, 1'b1);
        cyc(0, 1'b0);
        chk_decide("toggle_half", 1, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1'b1);
        cyc(0, 1'b0);
        chk_decide("toggle_full", 0, 1, 0);
        cyc(0, 1'b0);

        // Reset mid-window.
        for (int i = 0; i < 8; i++) cyc(8000, 1'b1);
        rst = 1'b1;
        din_valid = 1'b0;
        #2;
        chk_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        window(8000, 5, 0, 1, 1, 5, "post_rst");

        // Gapped valid stream.
        gapped(8000, 5, 1, 0, 5, "gap_hold");
        gapped(8000, 5, 2, 1, 5, "gap_step");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
